// File: rtl/mux16_scan_ctrl_if.sv
// Bundle between the scan controller and its surroundings: mux select/output,
// scan control strobes and the assembled-word valid/ready handshake.
interface mux16_scan_ctrl_if #(
    parameter int SEL_W = 4
);
    localparam int N_CH = 2 ** SEL_W;

    logic             start;
    logic             cont;
    logic             abort;
    logic [SEL_W-1:0] sel;
    logic             q;
    logic [N_CH-1:0]  dout;
    logic             dout_valid;
    logic             dout_ready;
    logic             busy;

    // System side: issues commands, drives the mux, consumes words.
    modport master (
        output start, cont, abort, q, dout_ready,
        input  sel, dout, dout_valid, busy
    );

    // Controller side.
    modport slave (
        input  start, cont, abort, q, dout_ready,
        output sel, dout, dout_valid, busy
    );
endinterface

// File: rtl/mux16_scan_ctrl.sv
// Scan controller for a 2**SEL_W:1 bit mux: steps sel through every channel,
// holds each for SETTLE cycles, samples q on the last held cycle and presents
// the assembled word on a valid/ready handshake. Single-shot or continuous.
module mux16_scan_ctrl #(
    parameter int SEL_W  = 4,
    parameter int SETTLE = 2
) (
    input  logic                clk,
    input  logic                rst,
    mux16_scan_ctrl_if.slave    bus
);
    localparam int                N_CH        = 2 ** SEL_W;
    localparam logic [7:0]        SETTLE_LAST = 8'(SETTLE - 1);
    localparam logic [SEL_W-1:0]  SEL_LAST    = SEL_W'(N_CH - 1);

    if (SETTLE < 1 || SETTLE > 255) begin : g_bad_settle
        $error("mux16_scan_ctrl: SETTLE must lie in 1..255");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_OUTPUT
    } state_t;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] sel_reg, sel_next;
    logic [7:0]       cnt_reg, cnt_next;
    logic             valid_reg, valid_next;
    logic             capture;
    logic [N_CH-1:0]  dout_reg;

    // State, select, settle counter and valid flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            sel_reg   <= '0;
            cnt_reg   <= '0;
            valid_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            sel_reg   <= sel_next;
            cnt_reg   <= cnt_next;
            valid_reg <= valid_next;
        end
    end

    // Next-state logic; abort overrides everything and start is only seen in idle.
    always_comb begin
        state_next = state_reg;
        sel_next   = sel_reg;
        cnt_next   = cnt_reg;
        valid_next = valid_reg;
        capture    = 1'b0;
        if (bus.abort) begin
            state_next = ST_IDLE;
            sel_next   = '0;
            cnt_next   = '0;
            valid_next = 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.start) begin
                        state_next = ST_SETTLE;
                        sel_next   = '0;
                        cnt_next   = '0;
                    end
                end
                ST_SETTLE: begin
                    if (cnt_reg == SETTLE_LAST) begin
                        // Last cycle of the hold: sample this channel, move on.
                        capture  = 1'b1;
                        cnt_next = '0;
                        if (sel_reg == SEL_LAST) begin
                            state_next = ST_OUTPUT;
                            valid_next = 1'b1;
                        end else begin
                            sel_next = sel_reg + SEL_W'(1);
                        end
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
                ST_OUTPUT: begin
                    if (valid_reg && bus.dout_ready) begin
                        valid_next = 1'b0;
                        sel_next   = '0;
                        cnt_next   = '0;
                        state_next = bus.cont ? ST_SETTLE : ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                    sel_next   = '0;
                    cnt_next   = '0;
                    valid_next = 1'b0;
                end
            endcase
        end
    end

    // One capture flop per channel; bits are overwritten in place, never cleared by a scan.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_bit
        // Load bit gi when the currently selected channel is sampled.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_reg[gi] <= 1'b0;
            end else if (capture && (sel_reg == SEL_W'(gi))) begin
                dout_reg[gi] <= bus.q;
            end
        end
    end

    assign bus.sel        = sel_reg;
    assign bus.dout       = dout_reg;
    assign bus.dout_valid = valid_reg;
    assign bus.busy       = (state_reg != ST_IDLE);
endmodule

// File: tb/tb_mux16_scan_ctrl.sv
// Bench for mux16_scan_ctrl: behavioural 16:1 mux on q, a timing/word model
// derived from the scan rules, directed scenarios plus random words.
module tb_mux16_scan_ctrl;
    localparam int SEL_W  = 4;
    localparam int N_CH   = 16;
    localparam int SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] mux_in = 16'h0000;

    int checks_total  = 0;
    int checks_passed = 0;

    mux16_scan_ctrl_if #(.SEL_W(SEL_W)) bus ();

    mux16_scan_ctrl #(.SEL_W(SEL_W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    assign bus.q = mux_in[bus.sel];

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue the scan-starting edge (start pulse or handshake edge), then follow the
    // scan cycle by cycle. At offset k after that edge, sel should be k/SETTLE
    // (capped at N_CH-1) and the coming edge samples channel (k+1)/SETTLE-1 when
    // (k+1) is a multiple of SETTLE. Optionally pulses start again at offset restart_k.
    task automatic run_scan(input bit do_start, input int restart_k,
                            output int lat, output logic [15:0] exp_word, output int sel_err);
        int k;
        int exp_sel;
        exp_word = 16'h0000;
        sel_err  = 0;
        if (do_start) bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        k = 0;
        while (bus.dout_valid !== 1'b1 && k < 200) begin
            exp_sel = k / SETTLE;
            if (exp_sel > N_CH - 1) exp_sel = N_CH - 1;
            if (bus.sel !== 4'(exp_sel) || bus.busy !== 1'b1) sel_err++;
            if (((k + 1) % SETTLE) == 0 && ((k + 1) / SETTLE) <= N_CH)
                exp_word[(k + 1) / SETTLE - 1] = mux_in[(k + 1) / SETTLE - 1];
            bus.start = (k == restart_k);
            tick();
            k++;
        end
        bus.start = 1'b0;
        lat = k;
    endtask

    initial begin
        int          lat, lat2, sel_err, n, bad;
        logic [15:0] exp_word, w;

        bus.start      = 1'b0;
        bus.cont       = 1'b0;
        bus.abort      = 1'b0;
        bus.dout_ready = 1'b1;

        // Reset state.
        #3;
        check("rst_sel", bus.sel, 0);
        check("rst_dout", bus.dout, 0);
        check("rst_valid", bus.dout_valid, 0);
        check("rst_busy", bus.busy, 0);
        #20 rst = 1'b0;
        tick();

        // 1. Single scan.
        mux_in = 16'hA5C3;
        run_scan(1'b1, -1, lat, exp_word, sel_err);
        $display("scan1: lat=%0d dout=%h", lat, bus.dout);
        check("s1_latency", lat, 32);
        check("s1_sel_walk", sel_err, 0);
        check("s1_word_model", exp_word, 16'hA5C3);
        check("s1_dout", bus.dout, exp_word);
        check("s1_sel_end", bus.sel, 15);
        tick();
        check("s1_valid_1cyc", bus.dout_valid, 0);
        check("s1_idle_busy", bus.busy, 0);
        check("s1_idle_sel", bus.sel, 0);

        // 2. Backpressure.
        mux_in = 16'h8001;
        bus.dout_ready = 1'b0;
        run_scan(1'b1, -1, lat, exp_word, sel_err);
        check("bp_latency", lat, 32);
        bad = 0;
        for (int i = 0; i < 7; i++) begin
            if (bus.dout !== exp_word || bus.dout_valid !== 1'b1 || bus.sel !== 4'd15 || bus.busy !== 1'b1) bad++;
            tick();
        end
        check("bp_hold_stable", bad, 0);
        check("bp_still_valid", bus.dout_valid, 1);
        check("bp_dout", bus.dout, 16'h8001);
        bus.dout_ready = 1'b1;
        tick();
        $display("backpressure: handshake done valid=%0b busy=%0b", bus.dout_valid, bus.busy);
        check("bp_after_valid", bus.dout_valid, 0);
        check("bp_after_busy", bus.busy, 0);

        // 3. Continuous mode.
        bus.cont = 1'b1;
        mux_in = 16'h0001;
        run_scan(1'b1, -1, lat, exp_word, sel_err);
        check("cont_w1_latency", lat, 32);
        check("cont_w1", bus.dout, 16'h0001);
        mux_in = 16'hFFFE;
        run_scan(1'b0, -1, lat2, exp_word, sel_err);
        $display("continuous: word2=%h period=%0d", bus.dout, lat2 + 1);
        check("cont_period", lat2 + 1, 33);
        check("cont_sel_walk", sel_err, 0);
        check("cont_w2", bus.dout, exp_word);
        bus.cont = 1'b0;
        tick();
        check("cont_stop_busy", bus.busy, 0);

        // 4. Walking one / walking zero.
        bad = 0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 16; k++) begin
                w = 16'h0001 << k;
                mux_in = (p == 0) ? w : ~w;
                run_scan(1'b1, -1, lat, exp_word, sel_err);
                if (lat != 32 || sel_err != 0 || bus.dout !== mux_in || exp_word !== mux_in) bad++;
                tick();
            end
        end
        $display("walking sweep: bad scans=%0d", bad);
        check("walk_sweep", bad, 0);

        // Random words.
        for (int r = 0; r < 6; r++) begin
            mux_in = 16'($urandom);
            run_scan(1'b1, -1, lat, exp_word, sel_err);
            $display("random scan %0d: in=%h dout=%h lat=%0d", r, mux_in, bus.dout, lat);
            check("rand_latency", lat, 32);
            check("rand_word", bus.dout, exp_word);
            tick();
            check("rand_valid_drop", bus.dout_valid, 0);
        end

        // 5. Abort mid-scan, abort with start, start while busy.
        mux_in = 16'h5A5A;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.sel !== 4'd7 && n < 100) begin
            tick();
            n++;
        end
        check("abort_reach_sel7", bus.sel, 7);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        $display("abort: sel=%0d busy=%0b valid=%0b", bus.sel, bus.busy, bus.dout_valid);
        check("abort_sel", bus.sel, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.dout_valid, 0);
        bad = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.dout_valid !== 1'b0 || bus.busy !== 1'b0) bad++;
            tick();
        end
        check("abort_stays_idle", bad, 0);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check("start_abort_idle", bus.busy, 0);
        tick();
        check("start_abort_idle2", bus.busy, 0);
        mux_in = 16'h3C96;
        run_scan(1'b1, 9, lat, exp_word, sel_err);
        $display("start while busy: lat=%0d dout=%h", lat, bus.dout);
        check("busy_start_latency", lat, 32);
        check("busy_start_word", bus.dout, exp_word);
        tick();
        check("busy_start_not_queued", bus.busy, 0);

        // 6. Asynchronous reset mid-scan.
        mux_in = 16'hFFFF;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        n = 0;
        while (bus.sel !== 4'd9 && n < 100) begin
            tick();
            n++;
        end
        check("arst_reach_sel9", bus.sel, 9);
        #2 rst = 1'b1;
        #1;
        $display("async reset: sel=%0d dout=%h busy=%0b valid=%0b", bus.sel, bus.dout, bus.busy, bus.dout_valid);
        check("arst_sel", bus.sel, 0);
        check("arst_dout", bus.dout, 0);
        check("arst_busy", bus.busy, 0);
        check("arst_valid", bus.dout_valid, 0);
        #20 rst = 1'b0;
        tick();
        mux_in = 16'($urandom);
        run_scan(1'b1, -1, lat, exp_word, sel_err);
        $display("post-reset scan: in=%h dout=%h lat=%0d", mux_in, bus.dout, lat);
        check("arst_new_latency", lat, 32);
        check("arst_new_word", bus.dout, exp_word);
        tick();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule
